// File: rtl/cmd_pkg.sv
// Shared command-protocol definitions for the UART host and the
// system controller's decoder: opcodes, command types, FSM states.
package cmd_pkg;

   localparam logic [7:0] RF_WR_CMD    = 8'hAA;
   localparam logic [7:0] RF_RD_CMD    = 8'hBB;
   localparam logic [7:0] ALU_W_OP_CMD = 8'hCC;
   localparam logic [7:0] ALU_NOP_CMD  = 8'hDD;

   typedef enum logic [1:0] {
      RF_WR    = 2'd0,
      RF_RD    = 2'd1,
      ALU_W_OP = 2'd2,
      ALU_NOP  = 2'd3
   } cmd_type_e;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RSP,
      DONE
   } state_e;

   function automatic logic [2:0] frame_len(cmd_type_e t);
      logic [2:0] n;
      n = 3'd2;
      unique case (t)
         RF_WR:    n = 3'd3;
         RF_RD:    n = 3'd2;
         ALU_W_OP: n = 3'd4;
         ALU_NOP:  n = 3'd2;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] rsp_len(cmd_type_e t);
      logic [1:0] n;
      n = 2'd0;
      unique case (t)
         RF_WR:    n = 2'd0;
         RF_RD:    n = 2'd1;
         ALU_W_OP: n = 2'd2;
         ALU_NOP:  n = 2'd2;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rsp_timeout_cnt.sv
// Response timeout counter: counts while enabled, clear has priority,
// tc flags the last allowed cycle before a timeout.
module rsp_timeout_cnt #(
   parameter int TO_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TO_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command initiator: frames commands for a UART transmitter
// and gathers the response bytes from a UART receiver, with timeout.
import cmd_pkg::*;

module uart_cmd_host #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TO_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic [1:0]              CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_A,
   input  logic [DATA_WIDTH-1:0]   CMD_B,
   input  logic [3:0]              CMD_FUN,
   output logic [DATA_WIDTH-1:0]   TX_BYTE,
   output logic                    TX_VALID,
   input  logic                    TX_READY,
   input  logic [DATA_WIDTH-1:0]   RX_BYTE,
   input  logic                    RX_VALID,
   output logic [2*DATA_WIDTH-1:0] RSP_DATA,
   output logic                    RSP_VALID,
   output logic                    RSP_TIMEOUT,
   output logic                    RX_STRAY
);

   typedef logic [DATA_WIDTH-1:0] byte_t;

   state_e     state;
   cmd_type_e  c_type;
   byte_t      c_addr, c_a, c_b, c_fun;
   logic [1:0] idx, rx_cnt, nxt_rx;
   logic       last_tx;
   logic       to_clr, to_en, to_tc;

   function automatic byte_t frame_byte(
      cmd_type_e  t,
      logic [1:0] i,
      byte_t      addr,
      byte_t      a,
      byte_t      b,
      byte_t      fun
   );
      byte_t r;
      r = '0;
      unique case (t)
         RF_WR:
            case (i)
               2'd0:    r = byte_t'(RF_WR_CMD);
               2'd1:    r = addr;
               default: r = a;
            endcase
         RF_RD:
            case (i)
               2'd0:    r = byte_t'(RF_RD_CMD);
               default: r = addr;
            endcase
         ALU_W_OP:
            case (i)
               2'd0:    r = byte_t'(ALU_W_OP_CMD);
               2'd1:    r = a;
               2'd2:    r = b;
               default: r = fun;
            endcase
         ALU_NOP:
            case (i)
               2'd0:    r = byte_t'(ALU_NOP_CMD);
               default: r = fun;
            endcase
      endcase
      return r;
   endfunction

   assign last_tx = ({1'b0, idx} == (frame_len(c_type) - 3'd1));
   assign nxt_rx  = rx_cnt + 2'd1;

   // Counter only runs in WAIT_RSP; any received byte restarts it.
   assign to_clr = (state != WAIT_RSP) || RX_VALID;
   assign to_en  = (state == WAIT_RSP);

   rsp_timeout_cnt #(
      .TO_WIDTH       (TO_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_to (
      .clk   (CLK),
      .rst_n (RST),
      .clr   (to_clr),
      .en    (to_en),
      .tc    (to_tc)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         c_type      <= RF_WR;
         c_addr      <= '0;
         c_a         <= '0;
         c_b         <= '0;
         c_fun       <= '0;
         idx         <= '0;
         rx_cnt      <= '0;
         CMD_READY   <= 1'b1;
         TX_BYTE     <= '0;
         TX_VALID    <= 1'b0;
         RSP_DATA    <= '0;
         RSP_VALID   <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
         RX_STRAY    <= 1'b0;
      end else begin
         RSP_VALID <= 1'b0;
         RX_STRAY  <= RX_VALID && (state != WAIT_RSP);
         unique case (state)
            IDLE: begin
               if (CMD_VALID) begin
                  c_type      <= cmd_type_e'(CMD_TYPE);
                  c_addr      <= byte_t'(CMD_ADDR);
                  c_a         <= CMD_A;
                  c_b         <= CMD_B;
                  c_fun       <= byte_t'(CMD_FUN);
                  idx         <= '0;
                  rx_cnt      <= '0;
                  RSP_DATA    <= '0;
                  RSP_TIMEOUT <= 1'b0;
                  CMD_READY   <= 1'b0;
                  TX_VALID    <= 1'b1;
                  TX_BYTE     <= frame_byte(cmd_type_e'(CMD_TYPE), 2'd0,
                                            byte_t'(CMD_ADDR), CMD_A,
                                            CMD_B, byte_t'(CMD_FUN));
                  state       <= SEND;
               end
            end
            SEND: begin
               if (TX_READY) begin
                  if (last_tx) begin
                     TX_VALID <= 1'b0;
                     if (rsp_len(c_type) == 2'd0) begin
                        RSP_VALID <= 1'b1;
                        state     <= DONE;
                     end else begin
                        state <= WAIT_RSP;
                     end
                  end else begin
                     idx     <= idx + 2'd1;
                     TX_BYTE <= frame_byte(c_type, idx + 2'd1, c_addr,
                                           c_a, c_b, c_fun);
                  end
               end
            end
            WAIT_RSP: begin
               if (RX_VALID) begin
                  if (rx_cnt == 2'd0)
                     RSP_DATA[DATA_WIDTH-1:0] <= RX_BYTE;
                  else
                     RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_BYTE;
                  rx_cnt <= nxt_rx;
                  if (nxt_rx == rsp_len(c_type)) begin
                     RSP_VALID <= 1'b1;
                     state     <= DONE;
                  end
               end else if (to_tc) begin
                  RSP_VALID   <= 1'b1;
                  RSP_TIMEOUT <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               CMD_READY <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Randomized bench for uart_cmd_host against a frame/response model
// built from the command protocol rules.
module tb_uart_cmd_host;

   localparam int T = 100;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [1:0]  CMD_TYPE = '0;
   logic [3:0]  CMD_ADDR = '0;
   logic [7:0]  CMD_A = '0;
   logic [7:0]  CMD_B = '0;
   logic [3:0]  CMD_FUN = '0;
   logic [7:0]  TX_BYTE;
   logic        TX_VALID;
   logic        TX_READY = 1'b0;
   logic [7:0]  RX_BYTE = '0;
   logic        RX_VALID = 1'b0;
   logic [15:0] RSP_DATA;
   logic        RSP_VALID;
   logic        RSP_TIMEOUT;
   logic        RX_STRAY;

   int total = 0;
   int bad   = 0;

   uart_cmd_host #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .TO_WIDTH       (16),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .CMD_VALID   (CMD_VALID),
      .CMD_READY   (CMD_READY),
      .CMD_TYPE    (CMD_TYPE),
      .CMD_ADDR    (CMD_ADDR),
      .CMD_A       (CMD_A),
      .CMD_B       (CMD_B),
      .CMD_FUN     (CMD_FUN),
      .TX_BYTE     (TX_BYTE),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .RX_BYTE     (RX_BYTE),
      .RX_VALID    (RX_VALID),
      .RSP_DATA    (RSP_DATA),
      .RSP_VALID   (RSP_VALID),
      .RSP_TIMEOUT (RSP_TIMEOUT),
      .RX_STRAY    (RX_STRAY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int pick_gap();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) return int'($urandom_range(1, 12));
      if (r == 6) return T - 1;
      if (r == 7) return T;
      return T + 1;
   endfunction

   // mode: 0 = TX_READY always high, 1 = toggling, 2 = random
   task automatic run_cmd(input int t, input logic [3:0] addr,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] fun, input int mode,
                          input int g0, input int g1,
                          input logic [7:0] r0, input logic [7:0] r1);
      logic [7:0]  exp_q[$];
      logic [7:0]  sent[$];
      int          gaps[2];
      logic [7:0]  rb[2];
      int          n_rsp, acc, cyc, k;
      logic [15:0] exp_d;
      logic        exp_to, stall, rxp, rdy, tog;
      logic [7:0]  held;

      exp_q.delete();
      sent.delete();
      case (t)
         0: begin
            exp_q.push_back(8'hAA);
            exp_q.push_back({4'h0, addr});
            exp_q.push_back(a);
         end
         1: begin
            exp_q.push_back(8'hBB);
            exp_q.push_back({4'h0, addr});
         end
         2: begin
            exp_q.push_back(8'hCC);
            exp_q.push_back(a);
            exp_q.push_back(b);
            exp_q.push_back({4'h0, fun});
         end
         default: begin
            exp_q.push_back(8'hDD);
            exp_q.push_back({4'h0, fun});
         end
      endcase
      n_rsp = (t == 0) ? 0 : (t == 1) ? 1 : 2;
      gaps[0] = g0;
      gaps[1] = g1;
      rb[0] = r0;
      rb[1] = r1;
      acc = 0;
      exp_to = 1'b0;
      exp_d = '0;
      for (int j = 0; j < n_rsp; j++) begin
         if (gaps[j] > T) begin
            exp_to = 1'b1;
            break;
         end
         exp_d = exp_d | (16'(rb[j]) << (8 * j));
         acc++;
      end

      k = 0;
      while (!CMD_READY && k < 10) begin
         @(negedge CLK);
         k++;
      end
      chk("ready", CMD_READY, 1);
      CMD_VALID = 1'b1;
      CMD_TYPE = 2'(t);
      CMD_ADDR = addr;
      CMD_A = a;
      CMD_B = b;
      CMD_FUN = fun;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      CMD_TYPE = 2'($urandom);
      CMD_ADDR = 4'($urandom);
      CMD_A = 8'($urandom);
      CMD_B = 8'($urandom);
      CMD_FUN = 4'($urandom);
      chk("to_clr", RSP_TIMEOUT, 0);
      chk("busy", CMD_READY, 0);

      stall = 1'b0;
      rxp = 1'b0;
      tog = 1'b1;
      held = '0;
      cyc = 0;
      while (sent.size() < exp_q.size() && cyc < 200) begin
         chk("txv", TX_VALID, 1);
         chk("stray", RX_STRAY, rxp);
         if (stall) chk("hold", TX_BYTE, held);
         case (mode)
            0: rdy = 1'b1;
            1: begin
               rdy = tog;
               tog = !tog;
            end
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         TX_READY = rdy;
         rxp = ($urandom_range(0, 4) == 0);
         RX_VALID = rxp;
         RX_BYTE = 8'hFF;
         if (rdy) sent.push_back(TX_BYTE);
         stall = !rdy;
         held = TX_BYTE;
         cyc++;
         @(negedge CLK);
         RX_VALID = 1'b0;
      end
      chk("tx_len", sent.size(), exp_q.size());
      for (int i = 0; i < sent.size() && i < exp_q.size(); i++)
         chk("tx_byte", sent[i], exp_q[i]);
      if (mode == 0) chk("tx_b2b", cyc, exp_q.size());
      chk("stray", RX_STRAY, rxp);
      chk("txv_off", TX_VALID, 0);
      TX_READY = 1'($urandom_range(0, 1));

      for (int j = 0; j < acc; j++) begin
         for (int w = 1; w < gaps[j]; w++) begin
            chk("early", RSP_VALID, 0);
            @(negedge CLK);
         end
         chk("early", RSP_VALID, 0);
         RX_VALID = 1'b1;
         RX_BYTE = rb[j];
         @(negedge CLK);
         RX_VALID = 1'b0;
      end
      if (exp_to) begin
         for (int w = 0; w < T; w++) begin
            chk("early", RSP_VALID, 0);
            @(negedge CLK);
         end
      end

      chk("rsp_valid", RSP_VALID, 1);
      chk("rsp_data", RSP_DATA, exp_d);
      chk("rsp_to", RSP_TIMEOUT, exp_to);
      chk("busy_done", CMD_READY, 0);
      @(negedge CLK);
      chk("rsp_pulse", RSP_VALID, 0);
      chk("ready_back", CMD_READY, 1);
      chk("to_hold", RSP_TIMEOUT, exp_to);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, CMD_READY, 1);
      chk({tag, "_txv"}, TX_VALID, 0);
      chk({tag, "_txb"}, TX_BYTE, 0);
      chk({tag, "_data"}, RSP_DATA, 0);
      chk({tag, "_rv"}, RSP_VALID, 0);
      chk({tag, "_to"}, RSP_TIMEOUT, 0);
      chk({tag, "_stray"}, RX_STRAY, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      @(negedge CLK);
      @(negedge CLK);
      chk_reset_vals("rst");
      RST = 1'b1;
      @(negedge CLK);

      run_cmd(0, 4'h3, 8'h5A, 8'h00, 4'h0, 0, 0, 0, 8'h00, 8'h00);
      run_cmd(1, 4'h2, 8'h00, 8'h00, 4'h0, 0, 10, 0, 8'h81, 8'h00);
      run_cmd(2, 4'h0, 8'h0A, 8'h14, 4'h2, 1, 3, 2, 8'hC8, 8'h00);
      run_cmd(3, 4'h0, 8'h00, 8'h00, 4'h0, 0, 5, T + 1, 8'h33, 8'h44);
      run_cmd(2, 4'h0, 8'h01, 8'h02, 4'h3, 2, T, T, 8'h12, 8'h34);
      run_cmd(1, 4'hF, 8'h00, 8'h00, 4'h0, 2, T + 1, 0, 8'h99, 8'h00);

      RX_VALID = 1'b1;
      RX_BYTE = 8'hFF;
      @(negedge CLK);
      RX_VALID = 1'b0;
      chk("idle_stray", RX_STRAY, 1);
      chk("idle_ready", CMD_READY, 1);
      @(negedge CLK);
      chk("idle_stray_off", RX_STRAY, 0);

      CMD_VALID = 1'b1;
      CMD_TYPE = 2'd2;
      CMD_A = 8'h11;
      CMD_B = 8'h22;
      CMD_FUN = 4'h3;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      TX_READY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_byte2", TX_BYTE, 8'h22);
      TX_READY = 1'b0;
      RST = 1'b0;
      #1;
      chk_reset_vals("arst");
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("no_rsp", RSP_VALID, 0);
      end
      run_cmd(2, 4'h0, 8'hA1, 8'hB2, 4'h5, 0, 1, 1, 8'h01, 8'h02);

      for (int n = 0; n < 40; n++) begin
         run_cmd(int'($urandom_range(0, 3)), 4'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                 pick_gap(), pick_gap(), 8'($urandom), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
